irq_pending_ctrl: RTL and testbench

- Interrupt request front-end that sits directly upstream of the 8-to-3 priority encoder.
- Captures 8 request lines into a pending register, applies a mask, and drives the encoder's request vector and enable.
- Reads the encoder's 3-bit index back on acknowledge to retire the granted request.
- Holds an in-service lockout until end-of-interrupt, so only one request is outstanding at a time.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_edge_capture.sv | 66 ++++++
 rtl/irq_pending_ctrl.sv | 95 +++++++++
 tb/tb_irq_pending_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt pending front-end.
package irq_pkg;

  localparam int unsigned N_IRQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // One-hot decode of an encoder index into a per-line vector.
  function automatic logic [N_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Per-line request capture: optional 2-flop synchronizer, previous-value
// register and pending bits with set-over-clear priority.
// Config macro: IRQ_SYNC_EN (defined = synchronize irq_in before capture).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   irq_in    : raw request lines
//   clr       : per-line clear (edge mode only)
//   pending   : captured pending bits
module irq_edge_capture
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] clr,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_prev;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync_q1;
  logic [N_IRQ-1:0] sync_q2;

  // Two-stage synchronizer for asynchronous request lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end
  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  // Previous sample; reset to 0 so a line high at release yields one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_prev <= '0;
    else     irq_prev <= irq_s;
  end

  generate
    if (EDGE_MODE) begin : g_edge
      // New edge applied after the clear so a coincident set is not lost.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr) | (irq_s & ~irq_prev);
      end
    end else begin : g_level
      logic unused_level;
      assign unused_level = ^{clr, irq_prev};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= irq_s;
      end
    end
  endgenerate

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt request front-end feeding an 8-to-3 priority encoder: pending
// capture, masking, offer/acknowledge handshake and in-service lockout.
// Config macro: IRQ_SYNC_EN (adds a 2-flop synchronizer on irq_in).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   irq_in      : raw request lines
//   mask        : 1 = line masked (pending bit kept)
//   pend_vec    : pending & ~mask, to encoder a input (combinational)
//   pend_en     : encoder enable, high in PRESENT
//   irq_valid   : request offered, high in PRESENT
//   ack         : acknowledge of offered request
//   enc_id      : encoder index fed back
//   eoi         : end of interrupt
//   in_service  : index captured at ack
//   busy        : high in SERVICE
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pend_vec,
  output logic             pend_en,
  output logic             irq_valid,
  input  logic             ack,
  input  logic [ID_W-1:0]  enc_id,
  input  logic             eoi,
  output logic [ID_W-1:0]  in_service,
  output logic             busy
);

  irq_state_t       state;
  irq_state_t       state_nxt;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  in_service_nxt;

  irq_edge_capture #(
    .EDGE_MODE(EDGE_MODE)
  ) u_capture (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .clr     (clr),
    .pending (pending)
  );

  assign pend_vec = pending & ~mask;

  // Next-state, retire vector and captured index.
  always_comb begin
    state_nxt      = state;
    clr            = '0;
    in_service_nxt = in_service;
    case (state)
      IDLE: begin
        if (|pend_vec) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (ack) begin
          state_nxt      = SERVICE;
          clr            = id_onehot(enc_id);
          in_service_nxt = enc_id;
        end else if (!(|pend_vec)) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_en    <= 1'b0;
      irq_valid  <= 1'b0;
      busy       <= 1'b0;
      in_service <= '0;
    end else begin
      state      <= state_nxt;
      pend_en    <= (state_nxt == PRESENT);
      irq_valid  <= (state_nxt == PRESENT);
      busy       <= (state_nxt == SERVICE);
      in_service <= in_service_nxt;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed, table-driven bench for irq_pending_ctrl (edge mode, no synchronizer).
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic       pend_en;
  logic       irq_valid;
  logic       ack;
  logic [2:0] enc_id;
  logic       eoi;
  logic [2:0] in_service;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask       (mask),
    .pend_vec   (pend_vec),
    .pend_en    (pend_en),
    .irq_valid  (irq_valid),
    .ack        (ack),
    .enc_id     (enc_id),
    .eoi        (eoi),
    .in_service (in_service),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] msk;
    logic       ak;
    logic [2:0] id;
    logic       eo;
    logic [7:0] e_pv;
    logic       e_valid;
    logic       e_busy;
    logic [2:0] e_is;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] irq, input logic [7:0] msk, input logic ak,
                     input logic [2:0] id, input logic eo, input logic [7:0] e_pv,
                     input logic e_valid, input logic e_busy, input logic [2:0] e_is);
    vec_t v;
    v.irq = irq; v.msk = msk; v.ak = ak; v.id = id; v.eo = eo;
    v.e_pv = e_pv; v.e_valid = e_valid; v.e_busy = e_busy; v.e_is = e_is;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e_pv, input logic e_valid,
                            input logic e_busy, input logic [2:0] e_is);
    check({tag, ".pend_vec"},   pend_vec, e_pv);
    check({tag, ".irq_valid"},  8'(irq_valid), 8'(e_valid));
    check({tag, ".pend_en"},    8'(pend_en), 8'(e_valid));
    check({tag, ".busy"},       8'(busy), 8'(e_busy));
    check({tag, ".in_service"}, 8'(in_service), 8'(e_is));
  endtask

  task automatic drive(input logic [7:0] irq, input logic [7:0] msk, input logic ak,
                       input logic [2:0] id, input logic eo);
    irq_in = irq; mask = msk; ack = ak; enc_id = id; eoi = eo;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

    //   irq    mask   ack id  eoi  pend_vec valid busy is
    // Single request on line 4
    add(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    add(8'h10, 8'h00, 0, 0, 0, 8'h10, 0, 0, 0);
    add(8'h00, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0);
    add(8'h00, 8'h00, 1, 4, 0, 8'h00, 0, 1, 4);
    add(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 4);
    add(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 4);
    add(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 4);
    // Two simultaneous requests, retired one at a time
    add(8'h81, 8'h00, 0, 0, 0, 8'h81, 0, 0, 4);
    add(8'h00, 8'h00, 0, 0, 0, 8'h81, 1, 0, 4);
    add(8'h00, 8'h00, 1, 7, 0, 8'h01, 0, 1, 7);
    add(8'h00, 8'h00, 0, 0, 1, 8'h01, 0, 0, 7);
    add(8'h00, 8'h00, 0, 0, 0, 8'h01, 1, 0, 7);
    add(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0);
    add(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
    // Masked request held pending, released by unmask
    add(8'h04, 8'h04, 0, 0, 0, 8'h00, 0, 0, 0);
    add(8'h00, 8'h04, 0, 0, 0, 8'h00, 0, 0, 0);
    add(8'h00, 8'h00, 0, 0, 0, 8'h04, 1, 0, 0);
    add(8'h00, 8'h00, 1, 2, 0, 8'h00, 0, 1, 2);
    add(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 2);
    // Mask raised while offered: withdraw without clearing
    add(8'h02, 8'h00, 0, 0, 0, 8'h02, 0, 0, 2);
    add(8'h00, 8'h00, 0, 0, 0, 8'h02, 1, 0, 2);
    add(8'h00, 8'h02, 0, 0, 0, 8'h00, 0, 0, 2);
    add(8'h00, 8'h02, 0, 0, 0, 8'h00, 0, 0, 2);
    add(8'h00, 8'h00, 0, 0, 0, 8'h02, 1, 0, 2);
    add(8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 1, 1);
    add(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1);
    // New edge coincident with ack of the same line: set wins
    add(8'h08, 8'h00, 0, 0, 0, 8'h08, 0, 0, 1);
    add(8'h00, 8'h00, 0, 0, 0, 8'h08, 1, 0, 1);
    add(8'h08, 8'h00, 1, 3, 0, 8'h08, 0, 1, 3);
    add(8'h00, 8'h00, 0, 0, 0, 8'h08, 0, 1, 3);
    add(8'h00, 8'h00, 0, 0, 1, 8'h08, 0, 0, 3);
    add(8'h00, 8'h00, 0, 0, 0, 8'h08, 1, 0, 3);
    add(8'h00, 8'h00, 0, 0, 1, 8'h08, 1, 0, 3);   // eoi outside SERVICE ignored
    add(8'h00, 8'h00, 1, 3, 0, 8'h00, 0, 1, 3);
    add(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0, 3);
    add(8'h00, 8'h00, 1, 5, 0, 8'h00, 0, 0, 3);   // ack outside PRESENT ignored

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].irq, vecs[i].msk, vecs[i].ak, vecs[i].id, vecs[i].eo);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_pv, vecs[i].e_valid,
                 vecs[i].e_busy, vecs[i].e_is);
    end

    // Build SERVICE with all lines pending, then reset mid-operation
    drive(8'hFF, 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_outs("fill", 8'hFF, 1'b0, 1'b0, 3'd3);
    drive(8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_outs("offer_ff", 8'hFF, 1'b1, 1'b0, 3'd3);
    drive(8'h01, 8'h00, 1'b1, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_outs("svc_ff", 8'hFF, 1'b0, 1'b1, 3'd0);
    drive(8'h00, 8'h00, 1'b0, 3'd6, 1'b0);
    @(posedge clk); #1;
    check_outs("svc_ff_hold", 8'hFF, 1'b0, 1'b1, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 8'h00, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_outs($sformatf("post_rst%0d", c), 8'h00, 1'b0, 1'b0, 3'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
